// File: rtl/trigger_pkg.sv
`default_nettype none
// trigger_pkg: mode/state encodings and default constants for multi_trigger_gen (rev 1.0)
package trigger_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_CONT    = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_BURST   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_CNT_W      = 32;
  localparam int DEF_BURST_W    = 8;
  localparam int DEF_PERIOD_CYC = 600000;
  localparam int DEF_WIDTH_CYC  = 120;
  localparam int DEF_AUTO_RUN   = 1;

endpackage
`default_nettype wire

// File: rtl/trigger_channel.sv
`default_nettype none
// trigger_channel: one channel with shadow/active config, state machine and counters (rev 1.0)
module trigger_channel
  import trigger_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int BURST_W    = DEF_BURST_W,
  parameter int DEF_PERIOD = DEF_PERIOD_CYC,
  parameter int DEF_WIDTH  = DEF_WIDTH_CYC,
  parameter int AUTO_RUN   = DEF_AUTO_RUN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_width,
  input  logic [CNT_W-1:0]   cfg_phase,
  input  logic [1:0]         cfg_mode,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               trigger,
  output logic               busy,
  output logic               done
);

  logic [CNT_W-1:0]   sh_period, sh_width, sh_phase;
  mode_e              sh_mode;
  logic [BURST_W-1:0] sh_burst;

  logic [CNT_W-1:0]   nx_period, nx_width, nx_phase, nx_last;
  mode_e              nx_mode;
  logic [BURST_W-1:0] nx_burst, nx_burst_last;

  logic [CNT_W-1:0]   act_width, act_last;
  mode_e              act_mode;
  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [BURST_W-1:0] rem;
  logic               auto_pend;

  // A write in the same cycle as a load takes effect immediately.
  always_comb begin
    nx_period = sh_period;
    nx_width  = sh_width;
    nx_phase  = sh_phase;
    nx_mode   = sh_mode;
    nx_burst  = sh_burst;
    if (cfg_we) begin
      nx_period = cfg_period;
      nx_width  = cfg_width;
      nx_phase  = cfg_phase;
      nx_mode   = mode_e'(cfg_mode);
      nx_burst  = cfg_burst;
    end
  end

  assign nx_last       = (nx_period == '0) ? '0 : nx_period - CNT_W'(1);
  assign nx_burst_last = (nx_burst == '0) ? '0 : nx_burst - BURST_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_period <= CNT_W'(DEF_PERIOD);
      sh_width  <= CNT_W'(DEF_WIDTH);
      sh_phase  <= '0;
      sh_mode   <= MODE_CONT;
      sh_burst  <= BURST_W'(1);
    end else if (cfg_we) begin
      sh_period <= nx_period;
      sh_width  <= nx_width;
      sh_phase  <= nx_phase;
      sh_mode   <= nx_mode;
      sh_burst  <= nx_burst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      trigger   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      act_width <= '0;
      act_last  <= '0;
      act_mode  <= MODE_CONT;
      auto_pend <= (AUTO_RUN != 0);
    end else begin
      done      <= 1'b0;
      auto_pend <= 1'b0;
      if (stop) begin
        state   <= ST_IDLE;
        trigger <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if ((start || auto_pend) && nx_mode != MODE_OFF) begin
              act_width <= nx_width;
              act_last  <= nx_last;
              act_mode  <= nx_mode;
              rem       <= nx_burst_last;
              busy      <= 1'b1;
              if (nx_phase != '0) begin
                state   <= ST_DELAY;
                cnt     <= nx_phase - CNT_W'(1);
                trigger <= 1'b0;
              end else begin
                state   <= ST_RUN;
                cnt     <= '0;
                trigger <= (nx_width != '0);
              end
            end
          end
          ST_DELAY: begin
            if (cnt == '0) begin
              state   <= ST_RUN;
              trigger <= (act_width != '0);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (cnt == act_last) begin
              if (act_mode == MODE_ONESHOT || (act_mode == MODE_BURST && rem == '0)) begin
                state   <= ST_IDLE;
                trigger <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else if (nx_mode == MODE_OFF) begin
                state   <= ST_IDLE;
                trigger <= 1'b0;
                busy    <= 1'b0;
              end else begin
                // Period boundary: pick up the shadow config for the next period.
                cnt       <= '0;
                act_width <= nx_width;
                act_last  <= nx_last;
                act_mode  <= nx_mode;
                rem       <= (act_mode == MODE_BURST) ? rem - BURST_W'(1) : nx_burst_last;
                trigger   <= (nx_width != '0);
              end
            end else begin
              cnt     <= cnt + CNT_W'(1);
              trigger <= (cnt + CNT_W'(1)) < act_width;
            end
          end
          default: begin
            state   <= ST_IDLE;
            trigger <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_trigger_gen.sv
`default_nettype none
// multi_trigger_gen: NUM_CH independent periodic trigger channels behind one config write port (rev 1.0)
module multi_trigger_gen
  import trigger_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int BURST_W    = DEF_BURST_W,
  parameter int DEF_PERIOD = DEF_PERIOD_CYC,
  parameter int DEF_WIDTH  = DEF_WIDTH_CYC,
  parameter int AUTO_RUN   = DEF_AUTO_RUN,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_width,
  input  logic [CNT_W-1:0]   cfg_phase,
  input  logic [1:0]         cfg_mode,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic [NUM_CH-1:0]  start,
  input  logic [NUM_CH-1:0]  stop,
  output logic [NUM_CH-1:0]  trigger,
  output logic [NUM_CH-1:0]  busy,
  output logic [NUM_CH-1:0]  done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trigger_channel #(
      .CNT_W      (CNT_W),
      .BURST_W    (BURST_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_WIDTH  (DEF_WIDTH),
      .AUTO_RUN   (AUTO_RUN)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we && (cfg_ch == CH_W'(i))),
      .cfg_period (cfg_period),
      .cfg_width  (cfg_width),
      .cfg_phase  (cfg_phase),
      .cfg_mode   (cfg_mode),
      .cfg_burst  (cfg_burst),
      .start      (start[i]),
      .stop       (stop[i]),
      .trigger    (trigger[i]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_trigger_gen.sv
`default_nettype none
// tb_multi_trigger_gen: scoreboard bench; expected {trigger,busy,done} per channel per cycle.
module tb_multi_trigger_gen;
  import trigger_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int BW  = 8;

  logic            clk;
  logic            rst;
  logic            cfg_we;
  logic [1:0]      cfg_ch;
  logic [CW-1:0]   cfg_period, cfg_width, cfg_phase;
  logic [1:0]      cfg_mode;
  logic [BW-1:0]   cfg_burst;
  logic [NCH-1:0]  start, stop;
  logic [NCH-1:0]  trigger, busy, done;

  multi_trigger_gen #(
    .NUM_CH(NCH), .CNT_W(CW), .BURST_W(BW),
    .DEF_PERIOD(10), .DEF_WIDTH(3), .AUTO_RUN(1)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_width(cfg_width), .cfg_phase(cfg_phase),
    .cfg_mode(cfg_mode), .cfg_burst(cfg_burst),
    .start(start), .stop(stop),
    .trigger(trigger), .busy(busy), .done(done)
  );

  typedef struct {
    int         cyc;
    int         ch;
    logic [2:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t keep[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int c, input int ch, input logic [2:0] v);
    exp_t e;
    e.cyc = c; e.ch = ch; e.val = v;
    sb.push_back(e);
  endtask

  // Expected trace from spec formulas: D delay cycles, nper periods of P with W high, optional done.
  task automatic push_seq(input int ch, input int t, input int d, input int p,
                          input int w, input int nper, input bit fin);
    int k;
    k = t;
    for (int i = 0; i < d; i++) begin push(k, ch, 3'b010); k++; end
    for (int n = 0; n < nper; n++)
      for (int j = 0; j < p; j++) begin
        push(k, ch, (j < w) ? 3'b110 : 3'b010);
        k++;
      end
    if (fin) begin
      push(k, ch, 3'b001);
      push(k + 1, ch, 3'b000);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int p, input int w, input int d,
                           input mode_e m, input int n);
    cfg_we     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = CW'(p);
    cfg_width  = CW'(w);
    cfg_phase  = CW'(d);
    cfg_mode   = m;
    cfg_burst  = BW'(n);
  endtask

  // Compare every expectation that falls due in the current cycle.
  always @(negedge clk) begin
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc <= cyc)
        check($sformatf("ch%0d_cyc%0d", sb[i].ch, sb[i].cyc),
              32'({trigger[sb[i].ch], busy[sb[i].ch], done[sb[i].ch]}), 32'(sb[i].val));
      else
        keep.push_back(sb[i]);
    end
    sb = keep;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_width = '0;
    cfg_phase = '0; cfg_mode = '0; cfg_burst = '0; start = '0; stop = '0;
    for (int c = 1; c <= 3; c++)
      for (int ch = 0; ch < NCH; ch++) push(c, ch, 3'b000);

    // Auto-run with defaults P=10 W=3 on every channel; ch0 keeps running.
    at(3); rst = 1'b0;
    push_seq(0, 4, 0, 10, 3, 3, 1'b0);
    for (int ch = 1; ch < NCH; ch++) begin push(4, ch, 3'b110); push(5, ch, 3'b000); end
    at(4); stop = 4'b1110;
    at(5); stop = '0;

    // ch1 one-shot with phase delay.
    at(6); cfg_write(1, 8, 2, 5, MODE_ONESHOT, 0);
    at(7); cfg_we = 1'b0; start = 4'b0010;
    push_seq(1, 8, 5, 8, 2, 1, 1'b1);

    // ch2 burst of three, restart attempt mid-burst.
    at(8); start = '0; cfg_write(2, 4, 1, 0, MODE_BURST, 3);
    at(9); cfg_we = 1'b0; start = 4'b0100;
    push_seq(2, 10, 0, 4, 1, 3, 1'b1);
    at(10); start = '0;

    // ch3: cfg and start together, W=P=5 constant high, then W=0, then OFF at boundary.
    at(12); cfg_write(3, 5, 5, 0, MODE_CONT, 0); start = 4'b1000;
    push_seq(3, 13, 0, 5, 5, 2, 1'b0);
    push_seq(3, 23, 0, 4, 0, 1, 1'b0);
    push(27, 3, 3'b000); push(28, 3, 3'b000);
    at(13); cfg_we = 1'b0; start = 4'b0100;
    at(14); start = '0;
    at(20); cfg_write(3, 4, 0, 0, MODE_CONT, 0);
    at(21); cfg_we = 1'b0;
    at(25); cfg_write(3, 4, 0, 0, MODE_OFF, 0);
    at(26); cfg_we = 1'b0;

    // ch0 reconfigured at c=5; new pattern from the next period, then stop mid-pulse.
    at(29); cfg_write(0, 6, 4, 0, MODE_CONT, 0);
    push_seq(0, 34, 0, 6, 4, 1, 1'b0);
    push(40, 0, 3'b110); push(41, 0, 3'b110); push(42, 0, 3'b000); push(43, 0, 3'b000);

    // ch1 start and stop together stays idle.
    at(30); cfg_we = 1'b0; start = 4'b0010; stop = 4'b0010;
    for (int c = 31; c <= 33; c++) push(c, 1, 3'b000);
    at(31); start = '0; stop = '0;
    at(41); stop = 4'b0001;
    at(42); stop = '0;

    // ch2 P=0 behaves as P=1: burst of 3 after D=2.
    at(44); cfg_write(2, 0, 1, 2, MODE_BURST, 3);
    at(45); cfg_we = 1'b0; start = 4'b0100;
    push_seq(2, 46, 2, 1, 1, 3, 1'b1);

    // ch1 burst with N=0 behaves as one-shot.
    at(46); start = '0; cfg_write(1, 3, 1, 0, MODE_BURST, 0);
    at(47); cfg_we = 1'b0; start = 4'b0010;
    push_seq(1, 48, 0, 3, 1, 1, 1'b1);
    at(48); start = '0;

    // Reset mid-pulse on ch3, then auto-run with restored defaults.
    at(52); cfg_write(3, 4, 3, 0, MODE_CONT, 0);
    at(53); cfg_we = 1'b0; start = 4'b1000;
    push(54, 3, 3'b110); push(55, 3, 3'b110);
    at(54); start = '0;
    at(55); rst = 1'b1;
    for (int c = 56; c <= 57; c++)
      for (int ch = 0; ch < NCH; ch++) push(c, ch, 3'b000);
    at(57); rst = 1'b0;
    push_seq(0, 58, 0, 10, 3, 1, 1'b0);
    for (int ch = 1; ch < NCH; ch++) push(58, ch, 3'b110);

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
